// File: rtl/ps2_mouse_packet_tracker_pkg.sv
// rtl/ps2_mouse_packet_tracker_pkg.sv - shared constants for the PS/2 mouse packet tracker
// Purpose: FSM state encoding, PS/2 header bit positions, default screen size.
// Ports: none (package).
package ps2_mouse_packet_tracker_pkg;

  // Packet assembly FSM: B0 expects header, B1 expects dx, B2 expects dy.
  localparam logic [1:0] ST_B0 = 2'd0;
  localparam logic [1:0] ST_B1 = 2'd1;
  localparam logic [1:0] ST_B2 = 2'd2;

  // Header byte bit positions.
  localparam int HDR_LEFT    = 0;
  localparam int HDR_RIGHT   = 1;
  localparam int HDR_ALWAYS1 = 3;
  localparam int HDR_X_SIGN  = 4;
  localparam int HDR_Y_SIGN  = 5;
  localparam int HDR_X_OVF   = 6;
  localparam int HDR_Y_OVF   = 7;

  // Default screen dimensions, shared with the VGA driver and drawing controller.
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  // Only the header fields that are used after the header byte is consumed.
  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic right;
    logic left;
  } hdr_t;

endpackage

// File: rtl/ps2_axis_accumulate.sv
// rtl/ps2_axis_accumulate.sv - one cursor axis: position plus signed delta, clamped
// Purpose: combinational next-position for one axis.
// Ports:
//   pos_i      current position, unsigned, 0..SIZE-1
//   delta_i    9-bit two's complement movement
//   invert_i   subtract the delta instead of adding (PS/2 Y is up-positive)
//   overflow_i movement invalid; hold position
//   pos_o      next position, clamped to 0..SIZE-1
module ps2_axis_accumulate #(
  parameter int SIZE = 640
) (
  input  logic [10:0] pos_i,
  input  logic [8:0]  delta_i,
  input  logic        invert_i,
  input  logic        overflow_i,
  output logic [10:0] pos_o
);

  localparam logic signed [11:0] MAX_S = 12'(SIZE - 1);

  logic signed [11:0] pos_s;
  logic signed [11:0] delta_s;
  logic signed [11:0] sum_s;

  always_comb begin
    pos_s   = signed'({1'b0, pos_i});
    delta_s = signed'({{3{delta_i[8]}}, delta_i});
    sum_s   = invert_i ? (pos_s - delta_s) : (pos_s + delta_s);
    if (overflow_i) begin
      pos_o = pos_i;
    end else if (sum_s[11]) begin
      pos_o = 11'd0;
    end else if (sum_s > MAX_S) begin
      pos_o = MAX_S[10:0];
    end else begin
      pos_o = sum_s[10:0];
    end
  end

endmodule

// File: rtl/ps2_mouse_packet_tracker.sv
// rtl/ps2_mouse_packet_tracker.sv - assembles PS/2 3-byte packets into a clamped cursor
// Purpose: track absolute cursor position and buttons from streaming-mode mouse bytes.
// Ports:
//   CLOCK, reset        system clock, asynchronous active-low reset
//   stream_en           bytes are only accepted while high
//   byte_valid/byte_data received byte strobe and value
//   recentre            level; loads START_X/START_Y each cycle it is high
//   mouseX, mouseY      cursor position (Y screen-down positive)
//   mouse1, mouse2      left/right buttons
//   packet_valid        pulse per completed packet
//   sync_error          pulse per discarded header byte or inter-byte timeout
module ps2_mouse_packet_tracker
  import ps2_mouse_packet_tracker_pkg::*;
#(
  parameter int SCREEN_W       = DEF_SCREEN_W,
  parameter int SCREEN_H       = DEF_SCREEN_H,
  parameter int START_X        = 320,
  parameter int START_Y        = 240,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        CLOCK,
  input  logic        reset,
  input  logic        stream_en,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        recentre,
  output logic [10:0] mouseX,
  output logic [10:0] mouseY,
  output logic        mouse1,
  output logic        mouse2,
  output logic        packet_valid,
  output logic        sync_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hdr_t             hdr_q, hdr_d;
  logic [7:0]       dx_q, dx_d;
  logic [10:0]      x_q, x_d, y_q, y_d;
  logic             m1_q, m1_d, m2_q, m2_d;
  logic             pv_q, pv_d, se_q, se_d;
  logic [10:0]      x_next, y_next;
  logic             timeout;

  // dx comes from the latched second byte; dy is the third byte arriving now,
  // so the update lands in the same edge that accepts it.
  ps2_axis_accumulate #(.SIZE(SCREEN_W)) u_axis_x (
    .pos_i      (x_q),
    .delta_i    ({hdr_q.x_sign, dx_q}),
    .invert_i   (1'b0),
    .overflow_i (hdr_q.x_ovf),
    .pos_o      (x_next)
  );

  ps2_axis_accumulate #(.SIZE(SCREEN_H)) u_axis_y (
    .pos_i      (y_q),
    .delta_i    ({hdr_q.y_sign, byte_data}),
    .invert_i   (1'b1),
    .overflow_i (hdr_q.y_ovf),
    .pos_o      (y_next)
  );

  // Terminal count cycle; a byte arriving in this same cycle still wins.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    dx_d    = dx_q;
    x_d     = x_q;
    y_d     = y_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    pv_d    = 1'b0;
    se_d    = 1'b0;

    if (!stream_en) begin
      state_d = ST_B0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_B0: begin
          cnt_d = '0;
          if (byte_valid) begin
            if (byte_data[HDR_ALWAYS1]) begin
              hdr_d.left   = byte_data[HDR_LEFT];
              hdr_d.right  = byte_data[HDR_RIGHT];
              hdr_d.x_sign = byte_data[HDR_X_SIGN];
              hdr_d.y_sign = byte_data[HDR_Y_SIGN];
              hdr_d.x_ovf  = byte_data[HDR_X_OVF];
              hdr_d.y_ovf  = byte_data[HDR_Y_OVF];
              state_d      = ST_B1;
            end else begin
              se_d = 1'b1;
            end
          end
        end
        ST_B1, ST_B2: begin
          if (byte_valid) begin
            cnt_d = '0;
            if (state_q == ST_B1) begin
              dx_d    = byte_data;
              state_d = ST_B2;
            end else begin
              x_d     = x_next;
              y_d     = y_next;
              m1_d    = hdr_q.left;
              m2_d    = hdr_q.right;
              pv_d    = 1'b1;
              state_d = ST_B0;
            end
          end else if (timeout) begin
            cnt_d   = '0;
            se_d    = 1'b1;
            state_d = ST_B0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_B0;
          cnt_d   = '0;
        end
      endcase
    end

    // Recentre overrides position only; buttons from a same-cycle packet stand.
    if (recentre) begin
      x_d = 11'(START_X);
      y_d = 11'(START_Y);
    end
  end

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_B0;
      cnt_q   <= '0;
      hdr_q   <= '0;
      dx_q    <= '0;
      x_q     <= 11'(START_X);
      y_q     <= 11'(START_Y);
      m1_q    <= 1'b0;
      m2_q    <= 1'b0;
      pv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      dx_q    <= dx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      pv_q    <= pv_d;
      se_q    <= se_d;
    end
  end

  assign mouseX       = x_q;
  assign mouseY       = y_q;
  assign mouse1       = m1_q;
  assign mouse2       = m2_q;
  assign packet_valid = pv_q;
  assign sync_error   = se_q;

endmodule

// File: tb/tb_ps2_mouse_packet_tracker.sv
// tb/tb_ps2_mouse_packet_tracker.sv - scoreboard bench for ps2_mouse_packet_tracker
module tb_ps2_mouse_packet_tracker;

  localparam int T = 200;

  logic        CLOCK;
  logic        reset;
  logic        stream_en;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        recentre;
  logic [10:0] mouseX;
  logic [10:0] mouseY;
  logic        mouse1;
  logic        mouse2;
  logic        packet_valid;
  logic        sync_error;

  ps2_mouse_packet_tracker #(
    .SCREEN_W       (640),
    .SCREEN_H       (480),
    .START_X        (320),
    .START_Y        (240),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .CLOCK        (CLOCK),
    .reset        (reset),
    .stream_en    (stream_en),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .recentre     (recentre),
    .mouseX       (mouseX),
    .mouseY       (mouseY),
    .mouse1       (mouse1),
    .mouse2       (mouse2),
    .packet_valid (packet_valid),
    .sync_error   (sync_error)
  );

  typedef struct {
    string name;
    bit    is_sync;
    int    x;
    int    y;
    bit    m1;
    bit    m2;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every cycle presenting packet_valid or sync_error consumes one expectation.
  initial begin
    ev_t e;
    forever begin
      @(negedge CLOCK);
      if (packet_valid || sync_error) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got pv=%0b se=%0b x=%0d y=%0d, required no event",
                   packet_valid, sync_error, mouseX, mouseY);
        end else begin
          e = exp_q.pop_front();
          if ((packet_valid == e.is_sync) || (sync_error != e.is_sync) ||
              (int'(mouseX) != e.x) || (int'(mouseY) != e.y) ||
              (mouse1 != e.m1) || (mouse2 != e.m2)) begin
            n_fail++;
            $display("FAIL %s: got pv=%0b se=%0b x=%0d y=%0d m1=%0b m2=%0b, required pv=%0b se=%0b x=%0d y=%0d m1=%0b m2=%0b",
                     e.name, packet_valid, sync_error, mouseX, mouseY, mouse1, mouse2,
                     !e.is_sync, e.is_sync, e.x, e.y, e.m1, e.m2);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic exp_pkt(input string n, input int x, input int y, input bit m1, input bit m2);
    exp_q.push_back('{name: n, is_sync: 1'b0, x: x, y: y, m1: m1, m2: m2});
  endtask

  task automatic exp_sync(input string n, input int x, input int y, input bit m1, input bit m2);
    exp_q.push_back('{name: n, is_sync: 1'b1, x: x, y: y, m1: m1, m2: m2});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge CLOCK);
    #1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic pulse_recentre();
    recentre = 1'b1;
    idle(1);
    recentre = 1'b0;
  endtask

  task automatic check_outputs(input string n, input int x, input int y,
                               input int m1, input int m2);
    check({n, "_x"}, int'(mouseX), x);
    check({n, "_y"}, int'(mouseY), y);
    check({n, "_m1"}, int'(mouse1), m1);
    check({n, "_m2"}, int'(mouse2), m2);
  endtask

  initial begin
    reset      = 1'b0;
    stream_en  = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    recentre   = 1'b0;
    idle(3);
    check_outputs("reset", 320, 240, 0, 0);
    check("reset_pv", int'(packet_valid), 0);
    check("reset_se", int'(sync_error), 0);
    reset = 1'b1;
    idle(2);
    stream_en = 1'b1;
    idle(1);

    exp_pkt("basic", 330, 235, 0, 0);
    send3(8'h08, 8'h0A, 8'h05);

    exp_pkt("move_a", 74, 100, 0, 0);
    send3(8'h18, 8'h00, 8'h87);
    exp_pkt("move_b", 5, 100, 0, 0);
    send3(8'h18, 8'hBB, 8'h00);
    exp_pkt("clamp_x_zero", 0, 100, 1, 0);
    send3(8'h19, 8'hF6, 8'h00);

    exp_pkt("y_down", 255, 356, 0, 0);
    send3(8'h28, 8'hFF, 8'h00);
    exp_pkt("clamp_y_max", 510, 479, 0, 0);
    send3(8'h28, 8'hFF, 8'h00);
    exp_pkt("clamp_x_max", 639, 479, 0, 1);
    send3(8'h0A, 8'hFF, 8'h00);

    pulse_recentre();
    check("recentre_x", int'(mouseX), 320);
    check("recentre_y", int'(mouseY), 240);

    exp_pkt("x_overflow", 320, 237, 0, 0);
    send3(8'h48, 8'h80, 8'h03);

    pulse_recentre();
    exp_sync("bad_header", 320, 240, 0, 0);
    send_byte(8'h00);
    exp_pkt("after_bad_header", 321, 239, 0, 0);
    send3(8'h08, 8'h01, 8'h01);

    pulse_recentre();
    exp_sync("timeout", 320, 240, 0, 0);
    send_byte(8'h08);
    idle(T);
    exp_pkt("after_timeout", 322, 240, 0, 0);
    send3(8'h08, 8'h02, 8'h00);

    exp_pkt("byte_beats_timeout", 325, 240, 0, 0);
    send_byte(8'h08);
    idle(T - 1);
    send_byte(8'h03);
    idle(T - 1);
    send_byte(8'h00);

    exp_pkt("y_overflow", 326, 240, 1, 1);
    send3(8'h8B, 8'h01, 8'h50);

    send_byte(8'h08);
    send_byte(8'h05);
    stream_en = 1'b0;
    idle(1);
    send_byte(8'h01);
    stream_en = 1'b1;
    exp_pkt("after_stream_off", 327, 240, 0, 0);
    send3(8'h08, 8'h01, 8'h00);

    exp_pkt("recentre_same_cycle", 320, 240, 1, 0);
    send_byte(8'h09);
    send_byte(8'h20);
    recentre = 1'b1;
    send_byte(8'h20);
    recentre = 1'b0;

    exp_pkt("recentre_next_pkt", 352, 208, 1, 0);
    send3(8'h09, 8'h20, 8'h20);
    pulse_recentre();
    check_outputs("recentre_after", 320, 240, 1, 0);

    send_byte(8'h08);
    reset = 1'b0;
    #1;
    check_outputs("midpkt_reset", 320, 240, 0, 0);
    check("midpkt_reset_pv", int'(packet_valid), 0);
    check("midpkt_reset_se", int'(sync_error), 0);
    idle(2);
    reset = 1'b1;
    idle(1);
    exp_pkt("after_reset", 324, 240, 0, 0);
    send3(8'h08, 8'h04, 8'h00);

    idle(5);
    check("events_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet_tracker.md
# ps2_mouse_packet_tracker

Consumes the byte stream from the PS/2 serial receiver after the mouse has been put into streaming mode, and assembles standard 3-byte movement packets. It keeps an absolute cursor position clamped to the visible screen and exposes button state. Its outputs drive the cursor inputs of the drawing controller (mouseX/mouseY) and the top-level button LEDs/visibility logic.

## Interface
Parameters:
- SCREEN_W, 640, horizontal extent; mouseX range 0..SCREEN_W-1
- SCREEN_H, 480, vertical extent; mouseY range 0..SCREEN_H-1
- START_X, 320, mouseX after reset/recentre
- START_Y, 240, mouseY after reset/recentre
- TIMEOUT_CYCLES, 100000, max CLOCK cycles between bytes of one packet (2 ms at 50 MHz)

Ports:
- CLOCK  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- stream_en  in  1  high once the mouse init sequence has finished; bytes ignored while low
- byte_valid  in  1  one-cycle strobe, byte_data valid
- byte_data  in  8  received PS/2 byte, parity already checked upstream
- recentre  in  1  synchronous level; forces position to START_X/START_Y
- mouseX  out  11  cursor X, unsigned
- mouseY  out  11  cursor Y, unsigned, screen-down positive
- mouse1  out  1  left button
- mouse2  out  1  right button
- packet_valid  out  1  one-cycle pulse on each completed packet
- sync_error  out  1  one-cycle pulse when a byte is discarded for framing

## Operation
- FSM states: B0, B1, B2. Reset state B0.
- B0: on byte_valid && stream_en, if byte_data[3]==1 latch as header, go B1; else discard, pulse sync_error, stay B0.
- B1: on byte accept, latch as dx byte, go B2.
- B2: on byte accept, latch dy byte, perform update, go B0.
- Header bits: [0] left, [1] right, [4] X sign, [5] Y sign, [6] X overflow, [7] Y overflow.
- dx = 9-bit two's complement {hdr[4], byte1}; dy = {hdr[5], byte2}; range -256..+255.
- newX = mouseX + sext(dx); newY = mouseY − sext(dy) (PS/2 Y is up-positive). 12-bit signed intermediates.
- Clamp: result <0 → 0; result > SIZE−1 → SIZE−1.
- Overflow bit set for an axis → that axis unchanged; other axis and buttons still update.
- mouse1/mouse2 update only on packet completion.
- Timeout: inter-byte counter runs in B1/B2, cleared on each accepted byte; reaching TIMEOUT_CYCLES → return to B0, pulse sync_error. Partial packet discarded, no output change.
- stream_en low: FSM forced to B0, counter cleared; outputs held.
- recentre high: mouseX/mouseY loaded with START_X/START_Y every cycle it is high; overrides a same-cycle packet position update; button update from that packet still applies; FSM unaffected.

## Timing
- Reset values: mouseX=START_X, mouseY=START_Y, mouse1=0, mouse2=0, packet_valid=0, sync_error=0, FSM=B0, counter=0.
- Latency: byte_valid of byte 3 in cycle N → new mouseX/mouseY/buttons and packet_valid high in cycle N+1.
- sync_error: high in cycle N+1 after the discarding byte or the timeout-terminal cycle.
- Back-to-back byte_valid on consecutive cycles accepted with no gaps.
- Timeout and byte_valid in same cycle: byte wins, counter cleared.
- Reset asserted mid-packet: immediate return to reset values; partial packet lost.

## Structure
- Shared package: FSM state encoding, header bit-position constants, default screen dimensions (shared with VGA driver and drawing controller).
- One sub-module natural: ps2_axis_accumulate (position + signed delta, invert flag, overflow gate, clamp to limit), instantiated once per axis.

## Test plan
- Reset, then stream_en=1, bytes 0x08,0x0A,0x05 → mouseX=330, mouseY=235, buttons 0, one packet_valid pulse.
- Bytes 0x19,0xF6,0x00 from (5,100) → dx=−10, mouseX clamps to 0, mouse1=1, mouseY=100.
- Bytes 0x48,0x80,0x03 from (320,240) → X overflow: mouseX=320, mouseY=237.
- Byte 0x00 in B0 → sync_error pulse, state B0; then 0x08,0x01,0x01 → mouseX=321, mouseY=239.
- 0x08 then idle 100000 cycles → sync_error pulse; following 0x08,0x02,0x00 parsed as fresh packet → mouseX=322.
- recentre high in the cycle after byte 3 of 0x09,0x20,0x20 → position 320/240, mouse1=1; reset asserted between bytes 1 and 2 → all outputs to reset values.
